// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the digit count.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10..15 are not valid BCD and decode to all segments off.
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Map each BCD code to its segment pattern
  always_comb begin
    seg = SEG_BLANK;
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// Each digit is lit for REFRESH_DIV clk cycles (REFRESH_DIV >= 2). The
// displayed value is a snapshot taken once per frame, at the end of the
// digit3 slot, so a frame never mixes old and new input values.
// Optional: define SSEG_LZ_BLANK_EN to blank leading zeros (digit0 and any
// digit with its decimal point requested are never blanked).
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  sseg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]      cnt;
  logic [1:0]            idx;
  logic [15:0]           digit_snap;
  logic [NUM_DIGITS-1:0] dp_snap;
  logic                  terminal;
  logic                  frame_load;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic [6:0]            seg_pat;
  logic                  blank;

  assign terminal   = (cnt == CNT_LAST);
  assign frame_load = terminal && (idx == 2'd3);
  assign cur_code   = digit_snap[idx*4 +: 4];
  assign cur_dp     = dp_snap[idx];

  // Refresh counter: counts 0..REFRESH_DIV-1 and wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      cnt <= '0;
    else if (terminal) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  // Scan index advances once per digit slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      idx <= 2'd0;
    else if (terminal) idx <= idx + 2'd1;
  end

  // Frame snapshot of digits/dp, plus a one-cycle tick marking the load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_snap <= '0;
      dp_snap    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_load;
      if (frame_load) begin
        digit_snap <= digits;
        dp_snap    <= dp_in;
      end
    end
  end

`ifdef SSEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;

  // A digit is a leading zero if it and every digit above it are zero
  always_comb begin
    lz    = '0;
    lz[3] = (digit_snap[15:12] == 4'd0);
    lz[2] = lz[3] && (digit_snap[11:8] == 4'd0);
    lz[1] = lz[2] && (digit_snap[7:4] == 4'd0);
    blank = lz[idx] && !cur_dp;
  end
`else
  assign blank = 1'b0;
`endif

  bcd_to_sseg u_dec (
    .code (cur_code),
    .seg  (seg_pat)
  );

  // Registered display outputs for the active slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an   <= AN_OFF;
      sseg <= SEG_BLANK;
      dp   <= 1'b1;
    end else if (blank) begin
      an   <= AN_OFF;
      sseg <= SEG_BLANK;
      dp   <= 1'b1;
    end else begin
      an   <= ~(4'b0001 << idx);
      sseg <= seg_pat;
      dp   <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver with REFRESH_DIV=4.
// The reference model works from elapsed cycles since reset release:
// the displayed slot and frame number follow from integer division, and
// the snapshot is whatever the inputs held at each frame-boundary edge.
module tb_sseg_scan_driver;

  localparam int D     = 4;
  localparam int FRAME = 4 * D;

  logic        clk;
  logic        reset_n;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int k;                 // rising edges since reset release
  logic [15:0] m_digits; // model snapshot
  logic [3:0]  m_dp;
  logic [6:0]  seg_tab [16];

  sseg_scan_driver #(.REFRESH_DIV(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .digits     (digits),
    .dp_in      (dp_in),
    .an         (an),
    .sseg       (sseg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b k=%0d t=%0t", tag, got, exp, k, $time);
    end
  endtask

  function automatic logic is_blank(input logic [15:0] d, input logic [3:0] p, input int i);
    logic b;
    b = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
    if (i > 0 && !p[i]) begin
      b = 1'b1;
      for (int j = i; j < 4; j++)
        if (d[j*4 +: 4] != 4'd0) b = 1'b0;
    end
`endif
    return b;
  endfunction

  // One clock: predict outputs after this edge, advance the model, compare
  task automatic step();
    int di;
    logic bl;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ft;
    @(posedge clk);
    k++;
    di = ((k - 1) / D) % 4;
    bl = is_blank(m_digits, m_dp, di);
    e_an  = bl ? 4'hF : ~(4'b0001 << di);
    e_seg = bl ? 7'h7F : seg_tab[m_digits[di*4 +: 4]];
    e_dp  = bl ? 1'b1 : ~m_dp[di];
    e_ft  = (k % FRAME) == 0;
    if (e_ft) begin
      m_digits = digits;
      m_dp     = dp_in;
    end
    #1;
    check("an", an, e_an);
    check("sseg", sseg, e_seg);
    check("dp", dp, e_dp);
    check("frame_tick", frame_tick, e_ft);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"}, an, 4'hF);
    check({tag, "_sseg"}, sseg, 7'h7F);
    check({tag, "_dp"}, dp, 1'b1);
    check({tag, "_ft"}, frame_tick, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n  = 1'b1;
    k        = 0;
    m_digits = '0;
    m_dp     = '0;
  endtask

  function automatic logic [3:0] rand_nib();
    return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;

    k        = 0;
    m_digits = '0;
    m_dp     = '0;
    reset_n  = 1'b0;
    digits   = 16'h1234;
    dp_in    = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    release_reset();
    #1;
    check_reset_vals("rst_rel");

    // Directed frame sequence with 1234 -> 5678 -> 00A7 -> 0007
    while (k < 80) begin
      step();
      if (k >= 1 && k <= 4) begin
        check("first_an", an, 4'b1110);
        check("first_sseg", sseg, 7'b1000000);
      end
      if (k == 15) check("ft_before", frame_tick, 1'b0);
      if (k == 16) check("ft_cycle17", frame_tick, 1'b1);
      if (k == 17) begin
        check("f1_d0_an", an, 4'b1110);
        check("f1_d0_sseg", sseg, 7'b0011001);
      end
      if (k == 20) digits = 16'h5678;
      if (k == 21) begin
        check("notear_an", an, 4'b1101);
        check("notear_sseg", sseg, 7'b0110000);
      end
      if (k == 29) begin
        check("f1_d3_an", an, 4'b0111);
        check("f1_d3_sseg", sseg, 7'b1111001);
      end
      if (k == 33) check("f2_d0_sseg", sseg, 7'b0000000);
      if (k == 40) digits = 16'h00A7;
      if (k == 54) begin
        check("illegal_an", an, 4'b1101);
        check("illegal_sseg", sseg, 7'b1111111);
      end
      if (k == 60) begin
        digits = 16'h0007;
        dp_in  = 4'b0100;
      end
`ifdef SSEG_LZ_BLANK_EN
      if (k == 65) begin
        check("lz_d0_an", an, 4'b1110);
        check("lz_d0_sseg", sseg, 7'b1111000);
      end
      if (k == 69) check("lz_d1_an", an, 4'b1111);
      if (k == 73) begin
        check("lz_d2_an", an, 4'b1011);
        check("lz_d2_sseg", sseg, 7'b1000000);
        check("lz_d2_dp", dp, 1'b0);
      end
      if (k == 77) check("lz_d3_an", an, 4'b1111);
`endif
    end

    // Randomized inputs, changed at arbitrary cycles including load edges
    for (int n = 0; n < 800; n++) begin
      step();
      if ($urandom_range(0, 2) == 0)
        digits = {rand_nib(), rand_nib(), rand_nib(), rand_nib()};
      if ($urandom_range(0, 3) == 0)
        dp_in = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
    end

    // Reset in the middle of the digit2 slot
    digits = 16'h1234;
    dp_in  = 4'b0000;
    while ((k % FRAME) != 9) step();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk);
    #1;
    check_reset_vals("rst_mid_hold");
    release_reset();
    step();
    check("restart_an", an, 4'b1110);
    check("restart_sseg", sseg, 7'b1000000);
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
